fusion_shift_accumulator: RTL and testbench
===========================================

# fusion_shift_accumulator

Sequential shift-and-add accumulator that sits directly downstream of the bit-brick adder tree. Each cycle it takes one signed partial sum from the full-adder tree, left-shifts it by a per-beat amount, and adds it into a running accumulator, fusing low-precision partial products into one wide result. A group of beats ends with `in_last`. The finished result is then handed off over a valid/ready handshake, together with a sticky overflow flag and a beat count.

## Interface
- `IN_W`, default 8: width of the signed partial sum from the adder tree.
- `ACC_W`, default 32: accumulator and result width, signed. Must be at least `IN_W`.
- `SH_W`, default 5: width of the shift field. `2**SH_W` must be no greater than `ACC_W`.
- `CNT_W`, default 8: width of the beat counter.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `in_valid` input 1: partial sum beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_data` input `IN_W`: signed partial sum.
- `in_shift` input `SH_W`: left-shift amount applied to `in_data`.
- `in_last` input 1: final beat of the current group.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output `ACC_W`: signed accumulated result.
- `out_overflow` output 1: sticky overflow for the group.
- `out_count` output `CNT_W`: number of beats in the group, saturating at all-ones.

## Operation
- **Beat acceptance.** A beat is accepted when `in_valid && in_ready`.
- **Term formation.** `term = sext(in_data, ACC_W) << in_shift`. Bits shifted above `ACC_W` are discarded.
- **Accumulation.** On the first beat of a group, `acc = term`. On later beats, `acc = acc + term`, with two's-complement wrap.
- **Overflow detection.** `out_overflow` is set for the group if either condition occurs on any beat:
  - the shift discards bits that are not copies of the result sign bit;
  - the add overflows, meaning both operands have the same sign and the sum has the opposite sign.
- **State machine.**
  - ACCUM (reset state): accepting beats. `in_ready = 1`. A non-last beat updates `acc`, `cnt` and the overflow flag, and stays in ACCUM. A last beat loads `out_data`, `out_overflow` and `out_count` from the final values (including that beat), then goes to DONE. The internal `acc`, `cnt` and flag are cleared so the next beat starts a new group.
  - DONE: `out_valid = 1` and `in_ready = out_ready`.
    - `out_ready = 0`: hold all outputs stable and stay in DONE.
    - `out_ready = 1` with no beat accepted: go to ACCUM.
    - `out_ready = 1` with a beat accepted: that beat starts the next group in the same cycle. If it is also `in_last`, reload the outputs and stay in DONE. Otherwise go to ACCUM.
- **Single-beat groups.** A group with `in_last` on its first beat is legal. The result is `term`, and the count is 1.
- **Beat counter.** Saturates at `2**CNT_W - 1`. Saturation does not set overflow.
- **Unaccepted input.** `in_data`, `in_shift` and `in_last` are ignored when the beat is not accepted.

## Timing
- **Reset values.** All outputs are 0 except `in_ready`, which is 1. `acc`, `cnt` and the overflow flag are 0, and the state is ACCUM.
- **Reset mid-group.** Discard the partial accumulation. After release, the next beat starts a new group. No output is emitted for the discarded group.
- **Latency.** `out_valid` rises the cycle after the `in_last` beat is accepted.
- **Throughput.**
  - One beat per cycle.
  - Groups run back-to-back with no bubble while `out_ready = 1`.
  - A stream of single-beat groups gives one result per cycle.
- **Combinational paths.** `in_ready` depends combinationally only on state and `out_ready`. There is no combinational path from `in_valid` or `in_data` to any output.
- **Output stability.** `out_data`, `out_overflow` and `out_count` stay stable while `out_valid && !out_ready`.

## Test plan
1. **Basic group.** Beats `(in_data, in_shift)` of (3,0), (-2,2), (5,4) with `in_last` on the third, and `out_ready = 1` → one cycle later `out_valid = 1`, `out_data = 75`, `out_count = 3`, `out_overflow = 0`.
2. **Single-beat back-to-back groups.** Beats (-1,0,last), (1,31,last) on consecutive cycles → results -1 then 0x80000000. The second sets `out_overflow = 1`, because bit 31 is not a sign copy. `in_ready` stays 1 throughout.
3. **Add overflow.** (127,24) then (127,24,last) → `out_data = 0xFE000000`, `out_overflow = 1`, `out_count = 2`. The next group, (1,0,last), returns `out_overflow = 0`.
4. **Backpressure.** Complete a group of one beat, (7,1,last) → `out_data = 14`. Hold `out_ready = 0` for 5 cycles: `in_ready = 0`, outputs stable, and beats presented during this time are not consumed. Raise `out_ready` while presenting (2,0,last) → next cycle `out_data = 2`.
5. **Reset mid-group.** Accept (9,0) and (9,0), assert `rst_n = 0` asynchronously mid-cycle, release, then send (4,0,last) → `out_data = 4`, `out_count = 1`. All outputs read 0 during reset.
6. **Counter saturation.** Send 300 beats of (0,0), the last with `in_last` → `out_count = 255`, `out_data = 0`, `out_overflow = 0`.

Source files
------------

// File: rtl/fusion_shift_accumulator.sv
// Shift-and-add accumulator fusing signed partial sums from the adder tree into
// one wide result, handed off over valid/ready with sticky overflow and beat count.
module fusion_shift_accumulator #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned SH_W  = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [SH_W-1:0]   in_shift,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_overflow,
  output logic [CNT_W-1:0]  out_count
);

  localparam int unsigned WIDE_W = 2 * ACC_W;
  localparam int unsigned EXT_W  = WIDE_W - IN_W;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic [WIDE_W-1:0]  wide;
  logic [ACC_W-1:0]   term;
  logic [ACC_W-1:0]   sum;
  logic               shift_ovf;
  logic               add_ovf;
  logic               ovf_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               accept;

  // A drained group leaves acc at zero, so acc + term also covers the first beat.
  always_comb begin
    wide      = {{EXT_W{in_data[IN_W-1]}}, in_data} << in_shift;
    term      = wide[ACC_W-1:0];
    shift_ovf = (wide[WIDE_W-1:ACC_W] != {ACC_W{term[ACC_W-1]}});
    sum       = acc + term;
    add_ovf   = (acc[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    ovf_next  = ovf | shift_ovf | add_ovf;
    cnt_next  = (&cnt) ? cnt : cnt + CNT_W'(1);
  end

  assign in_ready = (state == ACCUM) || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_count    <= '0;
    end else if (accept) begin
      if (in_last) begin
        out_data     <= sum;
        out_overflow <= ovf_next;
        out_count    <= cnt_next;
        out_valid    <= 1'b1;
        state        <= DONE;
        acc          <= '0;
        cnt          <= '0;
        ovf          <= 1'b0;
      end else begin
        acc          <= sum;
        cnt          <= cnt_next;
        ovf          <= ovf_next;
        out_valid    <= 1'b0;
        state        <= ACCUM;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
      state     <= ACCUM;
    end
  end

endmodule

// File: tb/tb_fusion_shift_accumulator.sv
// Directed, table-driven bench for fusion_shift_accumulator with hand-written
// sequences for mid-group reset and counter saturation.
module tb_fusion_shift_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [4:0]  in_shift;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_overflow;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  fusion_shift_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_shift     (in_shift),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [4:0]  sh;
    logic        last;
    logic        ordy;
    logic        exp_ready;
    logic        exp_ovalid;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, int d, int sh, logic last, logic ordy,
                              logic exp_ready, logic exp_ovalid,
                              logic [31:0] exp_data, logic exp_ovf, int exp_cnt);
    vec_t r;
    r.v = v; r.d = 8'(d); r.sh = 5'(sh); r.last = last; r.ordy = ordy;
    r.exp_ready = exp_ready; r.exp_ovalid = exp_ovalid;
    r.exp_data = exp_data; r.exp_ovf = exp_ovf; r.exp_cnt = 8'(exp_cnt);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, int d, int sh, logic last, logic ordy);
    in_valid  = v;
    in_data   = 8'(d);
    in_shift  = 5'(sh);
    in_last   = last;
    out_ready = ordy;
  endtask

  task automatic chk_result(string tag, logic [31:0] d, logic o, int c);
    chk({tag, ".out_valid"},    32'(out_valid), 32'd1);
    chk({tag, ".out_data"},     out_data, d);
    chk({tag, ".out_overflow"}, 32'(out_overflow), 32'(o));
    chk({tag, ".out_count"},    32'(out_count), 32'(c));
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, ".out_valid"},    32'(out_valid), 32'd0);
    chk({tag, ".out_data"},     out_data, 32'd0);
    chk({tag, ".out_overflow"}, 32'(out_overflow), 32'd0);
    chk({tag, ".out_count"},    32'(out_count), 32'd0);
    chk({tag, ".in_ready"},     32'(in_ready), 32'd1);
  endtask

  initial begin
    // basic group: 3 + (-2<<2) + (5<<4) = 75
    vecs.push_back(mk(1,   3,  0, 0, 1, 1, 0, 32'd0, 0, 0));
    vecs.push_back(mk(1,  -2,  2, 0, 1, 1, 0, 32'd0, 0, 0));
    vecs.push_back(mk(1,   5,  4, 1, 1, 1, 1, 32'd75, 0, 3));
    // single-beat groups back to back
    vecs.push_back(mk(1,  -1,  0, 1, 1, 1, 1, 32'hFFFF_FFFF, 0, 1));
    vecs.push_back(mk(1,   1, 31, 1, 1, 1, 1, 32'h8000_0000, 1, 1));
    // add overflow, then a clean group
    vecs.push_back(mk(1, 127, 24, 0, 1, 1, 0, 32'd0, 0, 0));
    vecs.push_back(mk(1, 127, 24, 1, 1, 1, 1, 32'hFE00_0000, 1, 2));
    vecs.push_back(mk(1,   1,  0, 1, 1, 1, 1, 32'd1, 0, 1));
    // backpressure: result held, presented beats not consumed
    vecs.push_back(mk(1,   7,  1, 1, 1, 1, 1, 32'd14, 0, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 99, 3, 1, 0, 0, 1, 32'd14, 0, 1));
    vecs.push_back(mk(1,   2,  0, 1, 1, 1, 1, 32'd2, 0, 1));
    vecs.push_back(mk(0,   0,  0, 0, 1, 1, 0, 32'd0, 0, 0));

    drive(0, 0, 0, 0, 1);
    rst_n = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(vecs[i].v, int'($signed(vecs[i].d)), int'(vecs[i].sh), vecs[i].last, vecs[i].ordy);
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      if (vecs[i].exp_ovalid)
        chk_result(tag, vecs[i].exp_data, vecs[i].exp_ovf, int'(vecs[i].exp_cnt));
      else
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    end

    // reset mid-group discards the partial sum
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1, 9, 0, 0, 1);
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 4, 0, 1, 1);
    @(posedge clk);
    #1;
    chk_result("after_reset", 32'd4, 0, 1);

    // 300 zero beats saturate the counter without flagging overflow
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1, 0, 0, (i == 299), 1);
      @(posedge clk);
    end
    #1;
    chk_result("saturate", 32'd0, 0, 255);

    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
